// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the two-client counter arbiter.
// Both the arbiter FSM and the count core import this package.
package cnt_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam logic CLI_UP = 1'b0;
  localparam logic CLI_DN = 1'b1;

  localparam int         BEATS   = 8;
  localparam logic [2:0] CNT_MAX = 3'(BEATS - 1);

  function automatic logic [1:0] cli_onehot(input logic cli);
    return cli ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cnt8_core.sv
// 3-bit beat counter with synchronous clear/enable; maps the count to an
// ascending (up-client) or descending (down-client) 4-bit result.
module cnt8_core
  import cnt_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       valid_i,
  input  logic       mode_i,
  output logic [2:0] cnt_o,
  output logic [3:0] result_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Down-client sees the bitwise complement, i.e. 15 down to 8.
  always_comb begin
    result_o = 4'd0;
    if (valid_i) begin
      result_o = (mode_i == CLI_DN) ? ~{1'b0, cnt_q} : {1'b0, cnt_q};
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_mode_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one 8-beat counter between an
// up-client and a down-client, WINDOWS windows per grant.
module cnt_mode_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int WINDOWS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       valid,
  output logic [3:0] result,
  output logic       last,
  output logic       busy,
  output arb_state_e state_dbg
);

  localparam logic [3:0] WIN_LAST = 4'(WINDOWS - 1);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] win_q, win_d;
  logic       rr_q, rr_d;

  logic [2:0] cnt;
  logic       cnt_clr;
  logic       cnt_en;
  logic       run;
  logic       owner;
  logic       other;
  logic       pick;
  logic       beat_end;
  logic       last_c;

  assign run      = (state_q == ST_RUN);
  assign owner    = grant_q[1];
  assign other    = ~owner;
  // Tie goes to the client not granted most recently.
  assign pick     = (&req) ? ~rr_q : req[1];
  assign beat_end = run && (cnt == CNT_MAX);
  assign last_c   = beat_end && ((win_q == WIN_LAST) || !req[owner]);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    rr_d    = rr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req != 2'b00) begin
          state_d = ST_RUN;
          grant_d = cli_onehot(pick);
          win_d   = 4'd0;
          rr_d    = pick;
        end
      end
      ST_RUN: begin
        if (last_c) begin
          cnt_clr = 1'b1;
          win_d   = 4'd0;
          if (req[other]) begin
            grant_d = cli_onehot(other);
            rr_d    = other;
          end else if (req[owner]) begin
            grant_d = cli_onehot(owner);
            rr_d    = owner;
          end else begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
          end
        end else begin
          // Requests are ignored mid-window; only the window count moves.
          cnt_en = 1'b1;
          if (beat_end) begin
            win_d = win_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      win_q   <= 4'd0;
      rr_q    <= CLI_DN;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  cnt8_core u_core (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .valid_i  (run),
    .mode_i   (owner),
    .cnt_o    (cnt),
    .result_o (result)
  );

  // valid marks every RUN cycle as a beat for the client on grant; there is
  // no backpressure, the client must accept each beat as it appears.
  assign grant     = grant_q;
  assign valid     = run;
  assign busy      = run;
  assign last      = last_c;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cnt_mode_arbiter.sv
// Directed bench for cnt_mode_arbiter: one instance with WINDOWS=1, one with
// WINDOWS=2, expected beats written out by hand.
module tb_cnt_mode_arbiter;
  import cnt_arb_pkg::*;

  logic       clk;
  logic       rst1, rst2;
  logic [1:0] req1, req2;
  logic [1:0] grant1, grant2;
  logic       valid1, valid2;
  logic [3:0] result1, result2;
  logic       last1, last2;
  logic       busy1, busy2;
  arb_state_e st1, st2;

  int n_checks;
  int n_errors;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cnt_mode_arbiter #(.WINDOWS(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .grant(grant1), .valid(valid1),
    .result(result1), .last(last1), .busy(busy1), .state_dbg(st1)
  );

  cnt_mode_arbiter #(.WINDOWS(2)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .grant(grant2), .valid(valid2),
    .result(result2), .last(last2), .busy(busy2), .state_dbg(st2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs settle 1 time unit after the edge; inputs change right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit d2, input logic [1:0] eg,
                         input logic ev, input logic [3:0] er, input logic el);
    logic [1:0] g;
    logic       v, b, l;
    logic [3:0] r;
    arb_state_e s;
    g = d2 ? grant2 : grant1;
    v = d2 ? valid2 : valid1;
    b = d2 ? busy2 : busy1;
    r = d2 ? result2 : result1;
    l = d2 ? last2 : last1;
    s = d2 ? st2 : st1;
    check_eq({tag, ".grant"}, int'(g), int'(eg));
    check_eq({tag, ".valid"}, int'(v), int'(ev));
    check_eq({tag, ".busy"}, int'(b), int'(ev));
    check_eq({tag, ".result"}, int'(r), int'(er));
    check_eq({tag, ".last"}, int'(l), int'(el));
    check_eq({tag, ".state"}, int'(s), int'(ev));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst1 = 1'b1; rst2 = 1'b1;
    req1 = 2'b00; req2 = 2'b00;
    step(); step();
    chk_out("rst1", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    chk_out("rst2", 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    // up-client held: 0..7 then re-grant 0,1; then drop and finish window
    rst1 = 1'b0;
    step();
    chk_out("idle_no_req", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    req1 = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("up_held[%0d]", i), 1'b0, 2'b01, 1'b1, 4'(i % 8), (i == 7));
    end
    req1 = 2'b00;
    for (int i = 2; i < 8; i++) begin
      step();
      chk_out($sformatf("up_drain[%0d]", i), 1'b0, 2'b01, 1'b1, 4'(i), (i == 7));
    end
    step();
    chk_out("up_idle", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);

    // down-client single-cycle pulse: 15..8, last on 8
    req1 = 2'b10;
    step();
    chk_out("dn_pulse[0]", 1'b0, 2'b10, 1'b1, 4'd15, 1'b0);
    req1 = 2'b00;
    for (int i = 1; i < 8; i++) begin
      step();
      chk_out($sformatf("dn_pulse[%0d]", i), 1'b0, 2'b10, 1'b1, 4'(15 - i), (i == 7));
    end
    step();
    chk_out("dn_idle", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);

    // both held: up, down, up back-to-back
    req1 = 2'b11;
    for (int i = 0; i < 24; i++) begin
      step();
      if ((i / 8) == 1)
        chk_out($sformatf("both[%0d]", i), 1'b0, 2'b10, 1'b1, 4'(15 - (i % 8)), (i % 8 == 7));
      else
        chk_out($sformatf("both[%0d]", i), 1'b0, 2'b01, 1'b1, 4'(i % 8), (i % 8 == 7));
    end
    req1 = 2'b00;
    step();
    chk_out("both_idle", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);

    // reset at beat 4 of a down window
    req1 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("dn_abort[%0d]", i), 1'b0, 2'b10, 1'b1, 4'(15 - i), 1'b0);
    end
    rst1 = 1'b1;
    req1 = 2'b11;
    step();
    chk_out("abort_rst", 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    rst1 = 1'b0;
    step();
    chk_out("post_rst_grant", 1'b0, 2'b01, 1'b1, 4'd0, 1'b0);
    rst1 = 1'b1;
    req1 = 2'b00;

    // WINDOWS=2: 16 beats, last only on the second 7
    rst2 = 1'b0;
    req2 = 2'b01;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_out($sformatf("w2_held[%0d]", i), 1'b1, 2'b01, 1'b1, 4'(i % 8), (i == 15));
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("w2_drop[%0d]", i), 1'b1, 2'b01, 1'b1, 4'(i), (i == 7));
      if (i == 3) req2 = 2'b00;
    end
    step();
    chk_out("w2_idle", 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
